// File: rtl/traffic_light_multi_if.sv
// Lamp and control bundle for the N-way traffic light controller.
// The controller owns the slave side; the intersection logic or bench owns the master side.
interface traffic_light_multi_if #(
    parameter int NUM_WAYS = 4
);
    localparam int AW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    logic                flash_mode;
    logic [NUM_WAYS-1:0] req;
    logic [NUM_WAYS-1:0] red;
    logic [NUM_WAYS-1:0] yellow;
    logic [NUM_WAYS-1:0] green;
    logic [AW-1:0]       active_way;
    logic [1:0]          phase;

    modport master (
        output flash_mode, req,
        input  red, yellow, green, active_way, phase
    );

    modport slave (
        input  flash_mode, req,
        output red, yellow, green, active_way, phase
    );
endinterface

// File: rtl/traffic_light_multi.sv
// N-way round-robin traffic light: GREEN, YELLOW, ALL-RED per way, with demand gap-out
// and a flashing-yellow maintenance mode. Lamps are registered from the next-state decode.
module traffic_light_multi #(
    parameter int NUM_WAYS          = 4,
    parameter int CNT_W             = 32,
    parameter int GREEN_CYCLES      = 1_500_000_000,
    parameter int MIN_GREEN_CYCLES  = 500_000_000,
    parameter int YELLOW_CYCLES     = 250_000_000,
    parameter int ALLRED_CYCLES     = 50_000_000,
    parameter int FLASH_HALF_CYCLES = 25_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    traffic_light_multi_if.slave bus
);
    localparam int AW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    localparam logic [1:0] PH_GREEN  = 2'b00;
    localparam logic [1:0] PH_YELLOW = 2'b01;
    localparam logic [1:0] PH_ALLRED = 2'b10;
    localparam logic [1:0] PH_FLASH  = 2'b11;

    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_HALF_CYCLES - 1);
    localparam logic [AW-1:0]    LAST_WAY    = AW'(NUM_WAYS - 1);

    logic [1:0]          phase_q, phase_n;
    logic [AW-1:0]       active_q, active_n;
    logic [CNT_W-1:0]    timer_q, timer_n;
    logic                toggle_q, toggle_n;
    logic [NUM_WAYS-1:0] dem_q, dem_n;
    logic [NUM_WAYS-1:0] red_q, red_n;
    logic [NUM_WAYS-1:0] yellow_q, yellow_n;
    logic [NUM_WAYS-1:0] green_q, green_n;

    logic [NUM_WAYS-1:0] active_oh;
    logic [NUM_WAYS-1:0] next_oh;
    logic                other_dem;
    logic                entering_green;

    always_comb begin
        active_oh = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (active_q == AW'(i)) active_oh[i] = 1'b1;
        end
        other_dem = |(dem_q & ~active_oh);
    end

    // Phase sequencing; flash_mode overrides everything except reset.
    always_comb begin
        phase_n  = phase_q;
        active_n = active_q;
        timer_n  = timer_q + CNT_W'(1);
        toggle_n = toggle_q;
        if (bus.flash_mode) begin
            if (phase_q != PH_FLASH) begin
                phase_n  = PH_FLASH;
                timer_n  = '0;
                toggle_n = 1'b1;
            end else if (timer_q == FLASH_LAST) begin
                timer_n  = '0;
                toggle_n = ~toggle_q;
            end
        end else begin
            case (phase_q)
                PH_GREEN: begin
                    if (timer_q == GREEN_LAST || (timer_q >= MIN_LAST && other_dem)) begin
                        phase_n = PH_YELLOW;
                        timer_n = '0;
                    end
                end
                PH_YELLOW: begin
                    if (timer_q == YELLOW_LAST) begin
                        phase_n = PH_ALLRED;
                        timer_n = '0;
                    end
                end
                PH_ALLRED: begin
                    if (timer_q == ALLRED_LAST) begin
                        phase_n  = PH_GREEN;
                        timer_n  = '0;
                        active_n = (active_q == LAST_WAY) ? '0 : active_q + AW'(1);
                    end
                end
                default: begin
                    // Leaving maintenance: clear through all-red and restart at way 0.
                    phase_n  = PH_ALLRED;
                    timer_n  = '0;
                    active_n = LAST_WAY;
                end
            endcase
        end
    end

    // Demand latches and next-state lamp decode.
    always_comb begin
        next_oh = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (active_n == AW'(i)) next_oh[i] = 1'b1;
        end
        entering_green = (phase_n == PH_GREEN) && (phase_q != PH_GREEN);

        dem_n = dem_q;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (bus.req[i] && !(phase_q == PH_GREEN && active_oh[i])) dem_n[i] = 1'b1;
            if (entering_green && next_oh[i]) dem_n[i] = 1'b0;
        end

        red_n    = '0;
        yellow_n = '0;
        green_n  = '0;
        case (phase_n)
            PH_GREEN: begin
                red_n   = ~next_oh;
                green_n = next_oh;
            end
            PH_YELLOW: begin
                red_n    = ~next_oh;
                yellow_n = next_oh;
            end
            PH_ALLRED: red_n = '1;
            default:   yellow_n = {NUM_WAYS{toggle_n}};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= PH_ALLRED;
            active_q <= LAST_WAY;
            timer_q  <= '0;
            toggle_q <= 1'b1;
            dem_q    <= '0;
            red_q    <= '1;
            yellow_q <= '0;
            green_q  <= '0;
        end else begin
            phase_q  <= phase_n;
            active_q <= active_n;
            timer_q  <= timer_n;
            toggle_q <= toggle_n;
            dem_q    <= dem_n;
            red_q    <= red_n;
            yellow_q <= yellow_n;
            green_q  <= green_n;
        end
    end

    assign bus.red        = red_q;
    assign bus.yellow     = yellow_q;
    assign bus.green      = green_q;
    assign bus.active_way = active_q;
    assign bus.phase      = phase_q;
endmodule

// File: tb/tb_traffic_light_multi.sv
// Bench for traffic_light_multi with 3 ways and short phase durations: directed
// per-segment vector table followed by a random run checking the safety invariants.
module tb_traffic_light_multi;
    localparam int N = 3;

    localparam logic [1:0] G  = 2'b00;
    localparam logic [1:0] Y  = 2'b01;
    localparam logic [1:0] AR = 2'b10;
    localparam logic [1:0] FL = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;

    traffic_light_multi_if #(.NUM_WAYS(N)) bus ();

    traffic_light_multi #(
        .NUM_WAYS         (N),
        .CNT_W            (8),
        .GREEN_CYCLES     (10),
        .MIN_GREEN_CYCLES (4),
        .YELLOW_CYCLES    (3),
        .ALLRED_CYCLES    (2),
        .FLASH_HALF_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // One record = inputs held for n edges, with the same expected state after each edge.
    typedef struct {
        bit         do_rst;
        bit         rst;
        bit         fl;
        logic [2:0] req;
        int         n;
        logic [1:0] ph;
        logic [1:0] way;
        bit         tog;
    } vec_t;

    vec_t vecs[$];
    int   chk_cnt = 0;
    int   err_cnt = 0;
    int   fail_lines = 0;

    task automatic add(input bit do_rst, input bit r, input bit fl, input logic [2:0] req,
                       input int n, input logic [1:0] ph, input logic [1:0] way, input bit tog);
        vec_t v;
        v.do_rst = do_rst; v.rst = r; v.fl = fl; v.req = req;
        v.n = n; v.ph = ph; v.way = way; v.tog = tog;
        vecs.push_back(v);
    endtask

    function automatic void decode(input logic [1:0] ph, input logic [1:0] way, input bit tog,
                                   output logic [2:0] r, output logic [2:0] y, output logic [2:0] g);
        logic [2:0] one;
        logic [2:0] oh;
        one = 3'b001;
        oh  = one << way;
        r = 3'b000; y = 3'b000; g = 3'b000;
        case (ph)
            G:       begin r = ~oh; g = oh; end
            Y:       begin r = ~oh; y = oh; end
            AR:      r = 3'b111;
            default: y = {3{tog}};
        endcase
    endfunction

    task automatic report_fail(input string msg);
        err_cnt++;
        if (fail_lines < 40) begin
            $display("FAIL %s", msg);
            fail_lines++;
        end
    endtask

    task automatic check_out(input string name, input logic [1:0] ph, input logic [1:0] way,
                             input bit tog);
        logic [2:0] r, y, g;
        bit         way_bad;
        decode(ph, way, tog, r, y, g);
        way_bad = (ph != FL) && (bus.active_way !== way);
        chk_cnt++;
        if (bus.phase !== ph || way_bad || bus.red !== r || bus.yellow !== y || bus.green !== g)
            report_fail($sformatf("%s: got phase=%0d way=%0d r=%b y=%b g=%b, required phase=%0d way=%0d r=%b y=%b g=%b",
                        name, bus.phase, bus.active_way, bus.red, bus.yellow, bus.green,
                        ph, way, r, y, g));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.flash_mode = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check_out("reset", AR, 2'd2, 1'b1);
        end
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] prev_ph;
        int         g_len;
        int         fl_left;
        int         green_ends;
        bit         ok;

        bus.req = '0;
        bus.flash_mode = 1'b0;

        // Plain round-robin with wrap: 45-cycle period.
        add(1, 0, 0, 3'b000, 1,  AR, 2, 0);
        add(0, 0, 0, 3'b000, 10, G,  0, 0);
        add(0, 0, 0, 3'b000, 3,  Y,  0, 0);
        add(0, 0, 0, 3'b000, 2,  AR, 0, 0);
        add(0, 0, 0, 3'b000, 10, G,  1, 0);
        add(0, 0, 0, 3'b000, 3,  Y,  1, 0);
        add(0, 0, 0, 3'b000, 2,  AR, 1, 0);
        add(0, 0, 0, 3'b000, 10, G,  2, 0);
        add(0, 0, 0, 3'b000, 3,  Y,  2, 0);
        add(0, 0, 0, 3'b000, 2,  AR, 2, 0);
        add(0, 0, 0, 3'b000, 1,  G,  0, 0);

        // Pulse on req[2] at way0 timer=1: gap-out at 4, order unchanged.
        add(1, 0, 0, 3'b000, 1,  AR, 2, 0);
        add(0, 0, 0, 3'b000, 2,  G,  0, 0);
        add(0, 0, 0, 3'b100, 1,  G,  0, 0);
        add(0, 0, 0, 3'b000, 1,  G,  0, 0);
        add(0, 0, 0, 3'b000, 3,  Y,  0, 0);
        add(0, 0, 0, 3'b000, 2,  AR, 0, 0);
        add(0, 0, 0, 3'b000, 4,  G,  1, 0);
        add(0, 0, 0, 3'b000, 3,  Y,  1, 0);
        add(0, 0, 0, 3'b000, 2,  AR, 1, 0);
        add(0, 0, 0, 3'b000, 10, G,  2, 0);
        add(0, 0, 0, 3'b000, 3,  Y,  2, 0);
        add(0, 0, 0, 3'b000, 2,  AR, 2, 0);
        add(0, 0, 0, 3'b000, 10, G,  0, 0);
        add(0, 0, 0, 3'b000, 1,  Y,  0, 0);

        // req[0] held through way0 green and into yellow.
        add(1, 0, 0, 3'b000, 1,  AR, 2, 0);
        add(0, 0, 0, 3'b001, 10, G,  0, 0);
        add(0, 0, 0, 3'b001, 3,  Y,  0, 0);
        add(0, 0, 0, 3'b000, 2,  AR, 0, 0);
        add(0, 0, 0, 3'b000, 4,  G,  1, 0);
        add(0, 0, 0, 3'b000, 3,  Y,  1, 0);
        add(0, 0, 0, 3'b000, 2,  AR, 1, 0);
        add(0, 0, 0, 3'b000, 4,  G,  2, 0);
        add(0, 0, 0, 3'b000, 3,  Y,  2, 0);
        add(0, 0, 0, 3'b000, 2,  AR, 2, 0);
        add(0, 0, 0, 3'b000, 10, G,  0, 0);
        add(0, 0, 0, 3'b000, 1,  Y,  0, 0);

        // Flash mid-yellow, then release; then a one-cycle flash pulse.
        add(1, 0, 0, 3'b000, 1,  AR, 2, 0);
        add(0, 0, 0, 3'b000, 10, G,  0, 0);
        add(0, 0, 0, 3'b000, 1,  Y,  0, 0);
        add(0, 0, 1, 3'b000, 2,  FL, 0, 1);
        add(0, 0, 1, 3'b000, 2,  FL, 0, 0);
        add(0, 0, 1, 3'b000, 2,  FL, 0, 1);
        add(0, 0, 1, 3'b000, 1,  FL, 0, 0);
        add(0, 0, 0, 3'b000, 2,  AR, 2, 0);
        add(0, 0, 0, 3'b000, 10, G,  0, 0);
        add(0, 0, 0, 3'b000, 1,  Y,  0, 0);
        add(0, 0, 1, 3'b000, 1,  FL, 0, 1);
        add(0, 0, 0, 3'b000, 2,  AR, 2, 0);
        add(0, 0, 0, 3'b000, 2,  G,  0, 0);

        // Reset mid-green of way1 discards a pending req[2] demand.
        add(1, 0, 0, 3'b000, 1,  AR, 2, 0);
        add(0, 0, 0, 3'b000, 10, G,  0, 0);
        add(0, 0, 0, 3'b000, 1,  Y,  0, 0);
        add(0, 0, 0, 3'b100, 1,  Y,  0, 0);
        add(0, 0, 0, 3'b000, 1,  Y,  0, 0);
        add(0, 0, 0, 3'b000, 2,  AR, 0, 0);
        add(0, 0, 0, 3'b000, 2,  G,  1, 0);
        add(0, 1, 0, 3'b100, 1,  AR, 2, 0);
        add(0, 0, 0, 3'b000, 1,  AR, 2, 0);
        add(0, 0, 0, 3'b000, 10, G,  0, 0);
        add(0, 0, 0, 3'b000, 1,  Y,  0, 0);

        foreach (vecs[i]) begin
            if (vecs[i].do_rst) do_reset();
            for (int k = 0; k < vecs[i].n; k++) begin
                rst = vecs[i].rst;
                bus.flash_mode = vecs[i].fl;
                bus.req = vecs[i].req;
                @(posedge clk); #1;
                check_out($sformatf("vec%0d.%0d", i, k), vecs[i].ph, vecs[i].way, vecs[i].tog);
            end
        end

        // Random demand and flash bursts; invariants and green length bounds.
        do_reset();
        prev_ph    = AR;
        g_len      = 0;
        fl_left    = 0;
        green_ends = 0;
        for (int c = 0; c < 20000; c++) begin
            bus.req = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            if (fl_left == 0 && $urandom_range(0, 399) == 0) fl_left = $urandom_range(1, 6);
            bus.flash_mode = (fl_left != 0);
            if (fl_left != 0) fl_left--;
            @(posedge clk); #1;

            ok = 1'b1;
            if (!$onehot0(bus.green)) ok = 1'b0;
            if ((bus.green & bus.yellow) != 3'b000) ok = 1'b0;
            if (bus.phase != FL) begin
                for (int w = 0; w < N; w++)
                    if (int'(bus.red[w]) + int'(bus.yellow[w]) + int'(bus.green[w]) != 1) ok = 1'b0;
            end else if (bus.red != 3'b000 || bus.green != 3'b000 ||
                         (bus.yellow != 3'b000 && bus.yellow != 3'b111)) begin
                ok = 1'b0;
            end
            if (bus.flash_mode && bus.phase != FL) ok = 1'b0;
            if (!bus.flash_mode && bus.phase == FL) ok = 1'b0;
            if (bus.phase == G && prev_ph != G && prev_ph != AR) ok = 1'b0;
            chk_cnt++;
            if (!ok)
                report_fail($sformatf("invariant cycle %0d: got phase=%0d r=%b y=%b g=%b prev=%0d fl=%b, required safe lamps",
                            c, bus.phase, bus.red, bus.yellow, bus.green, prev_ph, bus.flash_mode));

            if (bus.phase == G) begin
                g_len = (prev_ph == G) ? g_len + 1 : 1;
            end else if (prev_ph == G && bus.phase == Y) begin
                green_ends++;
                chk_cnt++;
                if (g_len < 4 || g_len > 10)
                    report_fail($sformatf("green_len cycle %0d: got %0d, required 4..10", c, g_len));
            end
            prev_ph = bus.phase;
        end
        chk_cnt++;
        if (green_ends < 100)
            report_fail($sformatf("progress: got %0d completed greens, required at least 100", green_ends));

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
